// File: rtl/mem_arbiter.sv
// CPU / data-break arbiter and sequencer for the 12-bit core memory.
// Define DB_INCR_EN to enable data-break read-increment-write (INC_WR, db_ovf).
`ifndef MEM_AWIDTH
`define MEM_AWIDTH 15
`endif

module mem_arbiter #(
    parameter int AW     = `MEM_AWIDTH,
    parameter int DB_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [11:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [11:0]   cpu_rdata,
    input  logic          db_req,
    input  logic          db_we,
    input  logic          db_inc,
    input  logic [AW-1:0] db_addr,
    input  logic [11:0]   db_wdata,
    output logic          db_ack,
    output logic          db_rvalid,
    output logic [11:0]   db_rdata,
    output logic          db_ovf,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic          mem_wren,
    output logic [11:0]   mem_wdata,
    input  logic [11:0]   mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD1,
`ifdef DB_INCR_EN
        S_INC_WR,
`endif
        S_RD2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(DB_MAX);

    state_t        state_q, state_d;
    logic [3:0]    streak_q, streak_d;
    logic          own_db_q, own_db_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic [11:0]   cpu_rdata_q, cpu_rdata_d;
    logic          db_ack_q, db_ack_d;
    logic          db_rvalid_q, db_rvalid_d;
    logic [11:0]   db_rdata_q, db_rdata_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          wren_q, wren_d;
    logic [11:0]   wdata_q, wdata_d;

    logic          grant_db, grant_cpu;
    logic          sel_we, sel_inc;
    logic [AW-1:0] sel_addr;
    logic [11:0]   sel_wdata;

    assign sel_we    = grant_db ? db_we    : cpu_we;
    assign sel_addr  = grant_db ? db_addr  : cpu_addr;
    assign sel_wdata = grant_db ? db_wdata : cpu_wdata;

`ifdef DB_INCR_EN
    logic inc_q, inc_d;
    logic ovf_q, ovf_d;
    assign sel_inc = grant_db && !db_we && db_inc;
    assign db_ovf  = ovf_q;
`else
    logic unused_db_inc;
    assign unused_db_inc = db_inc;
    assign sel_inc       = 1'b0;
    assign db_ovf        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        own_db_d     = own_db_q;
        cpu_ack_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        db_ack_d     = 1'b0;
        db_rvalid_d  = 1'b0;
        db_rdata_d   = db_rdata_q;
        raddr_d      = raddr_q;
        waddr_d      = waddr_q;
        wren_d       = 1'b0;
        wdata_d      = wdata_q;
        grant_db     = 1'b0;
        grant_cpu    = 1'b0;
`ifdef DB_INCR_EN
        inc_d        = inc_q;
        ovf_d        = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                // db has priority unless it has starved a waiting CPU
                grant_db  = db_req && !(cpu_req && streak_q == STREAK_MAX);
                grant_cpu = cpu_req && !grant_db;
                if (grant_db || grant_cpu) begin
                    own_db_d  = grant_db;
                    db_ack_d  = grant_db;
                    cpu_ack_d = grant_cpu;
`ifdef DB_INCR_EN
                    inc_d     = sel_inc;
`endif
                    if (sel_we) begin
                        state_d = S_WR;
                        wren_d  = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = sel_wdata;
                    end else begin
                        state_d = S_RD1;
                        raddr_d = sel_addr;
                    end
                end
            end
            S_WR:  state_d = S_IDLE;
            S_RD1: state_d = S_RD2;
            S_RD2: begin
`ifdef DB_INCR_EN
                if (inc_q) begin
                    state_d = S_INC_WR;
                    wren_d  = 1'b1;
                    waddr_d = raddr_q;
                    wdata_d = 12'(mem_rdata + 12'd1);
                end else
`endif
                begin
                    state_d = S_IDLE;
                    if (own_db_q) begin
                        db_rvalid_d = 1'b1;
                        db_rdata_d  = mem_rdata;
                    end else begin
                        cpu_rvalid_d = 1'b1;
                        cpu_rdata_d  = mem_rdata;
                    end
                end
            end
`ifdef DB_INCR_EN
            S_INC_WR: begin
                state_d     = S_IDLE;
                db_rvalid_d = 1'b1;
                db_rdata_d  = wdata_q;
                ovf_d       = (wdata_q == 12'd0);
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (!cpu_req || grant_cpu)
            streak_d = 4'd0;
        else if (grant_db && streak_q != STREAK_MAX)
            streak_d = streak_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            streak_q     <= 4'd0;
            own_db_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            db_ack_q     <= 1'b0;
            db_rvalid_q  <= 1'b0;
            db_rdata_q   <= '0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            wren_q       <= 1'b0;
            wdata_q      <= '0;
`ifdef DB_INCR_EN
            inc_q        <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            own_db_q     <= own_db_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            db_ack_q     <= db_ack_d;
            db_rvalid_q  <= db_rvalid_d;
            db_rdata_q   <= db_rdata_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
            wren_q       <= wren_d;
            wdata_q      <= wdata_d;
`ifdef DB_INCR_EN
            inc_q        <= inc_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign db_ack     = db_ack_q;
    assign db_rvalid  = db_rvalid_q;
    assign db_rdata   = db_rdata_q;
    assign mem_raddr  = raddr_q;
    assign mem_waddr  = waddr_q;
    assign mem_wren   = wren_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and random CPU/data-break traffic against a
// behavioural memory model, expected read responses queued per master.
`timescale 1ns/1ps

module tb_mem_arbiter;
    localparam int AW  = 15;
    localparam int DBM = 4;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [11:0]   cpu_wdata = '0;
    logic          cpu_ack, cpu_rvalid;
    logic [11:0]   cpu_rdata;
    logic          db_req = 1'b0, db_we = 1'b0, db_inc = 1'b0;
    logic [AW-1:0] db_addr = '0;
    logic [11:0]   db_wdata = '0;
    logic          db_ack, db_rvalid, db_ovf;
    logic [11:0]   db_rdata;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic          mem_wren;
    logic [11:0]   mem_wdata;
    logic [11:0]   mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DB_MAX(DBM)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .db_req(db_req), .db_we(db_we), .db_inc(db_inc), .db_addr(db_addr),
        .db_wdata(db_wdata), .db_ack(db_ack), .db_rvalid(db_rvalid),
        .db_rdata(db_rdata), .db_ovf(db_ovf),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wren(mem_wren),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [11:0] init_word(input int i);
        return 12'((i * 37 + 5) ^ (i >> 3));
    endfunction

    // core memory: registered read, write on mem_wren
    logic [11:0] core [0:MSZ-1];
    initial begin
        for (int i = 0; i < MSZ; i++) core[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_wren) core[mem_waddr] <= mem_wdata;
            mem_rdata <= core[mem_raddr];
        end
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic ok,
                       input longint act, input longint exp);
        checks++;
        if (ok === 1'b1) passed++;
        else $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] data;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        db_q[$];
    logic        glog[$];
    logic [11:0] ref_mem [0:MSZ-1];
    int          flush_cnt = 0;
    bit          mon_en = 0;

    // monitor / scoreboard: model applied in grant order, responses checked
    initial begin
        int          seen_flush;
        int          wr_cyc, inc_cyc;
        logic [AW-1:0] wr_addr, inc_addr;
        logic [11:0] wr_data, inc_data, v;
        logic        exp_w;
        exp_t        e;
        seen_flush = 0;
        wr_cyc = -10;
        inc_cyc = -10;
        wr_addr = '0; inc_addr = '0; wr_data = '0; inc_data = '0;
        for (int i = 0; i < MSZ; i++) ref_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            #1;
            if (flush_cnt != seen_flush) begin
                seen_flush = flush_cnt;
                cpu_q.delete();
                db_q.delete();
                wr_cyc = -10;
                inc_cyc = -10;
            end
            if (mon_en) begin
                if (cpu_ack && db_ack)
                    chk("single_grant", 1'b0, 2, 1);
                if (cpu_ack) begin
                    glog.push_back(1'b0);
                    if (cpu_we) begin
                        ref_mem[cpu_addr] = cpu_wdata;
                        wr_cyc = cyc; wr_addr = cpu_addr; wr_data = cpu_wdata;
                    end else begin
                        cpu_q.push_back('{ref_mem[cpu_addr], 1'b0, cyc + 2});
                    end
                end
                if (db_ack) begin
                    glog.push_back(1'b1);
                    if (db_we) begin
                        ref_mem[db_addr] = db_wdata;
                        wr_cyc = cyc; wr_addr = db_addr; wr_data = db_wdata;
                    end
`ifdef DB_INCR_EN
                    else if (db_inc) begin
                        v = 12'(ref_mem[db_addr] + 12'd1);
                        ref_mem[db_addr] = v;
                        inc_cyc = cyc + 2; inc_addr = db_addr; inc_data = v;
                        db_q.push_back('{v, v == 12'd0, cyc + 3});
                    end
`endif
                    else begin
                        db_q.push_back('{ref_mem[db_addr], 1'b0, cyc + 2});
                    end
                end
                exp_w = (cyc == wr_cyc) || (cyc == inc_cyc);
                chk("mem_wren", mem_wren === exp_w, mem_wren, exp_w);
                if (exp_w && cyc == wr_cyc) begin
                    chk("wr_addr", mem_waddr === wr_addr, mem_waddr, wr_addr);
                    chk("wr_data", mem_wdata === wr_data, mem_wdata, wr_data);
                end
                if (exp_w && cyc == inc_cyc) begin
                    chk("inc_addr", mem_waddr === inc_addr, mem_waddr, inc_addr);
                    chk("inc_data", mem_wdata === inc_data, mem_wdata, inc_data);
                end
                if (cpu_q.size() > 0 && cpu_q[0].due < cyc) begin
                    e = cpu_q.pop_front();
                    chk("cpu_rvalid_missing", 1'b0, cyc, e.due);
                end
                if (db_q.size() > 0 && db_q[0].due < cyc) begin
                    e = db_q.pop_front();
                    chk("db_rvalid_missing", 1'b0, cyc, e.due);
                end
                if (cpu_rvalid) begin
                    chk("cpu_rvalid_expected", cpu_q.size() > 0, cpu_q.size(), 1);
                    if (cpu_q.size() > 0) begin
                        e = cpu_q.pop_front();
                        chk("cpu_rdata", cpu_rdata === e.data, cpu_rdata, e.data);
                        chk("cpu_rlat", cyc == e.due, cyc, e.due);
                    end
                end
                if (db_rvalid) begin
                    chk("db_rvalid_expected", db_q.size() > 0, db_q.size(), 1);
                    if (db_q.size() > 0) begin
                        e = db_q.pop_front();
                        chk("db_rdata", db_rdata === e.data, db_rdata, e.data);
                        chk("db_ovf", db_ovf === e.ovf, db_ovf, e.ovf);
                        chk("db_rlat", cyc == e.due, cyc, e.due);
                    end
                end else begin
                    chk("db_ovf_idle", db_ovf === 1'b0, db_ovf, 0);
                end
            end
        end
    end

    task automatic cpu_op(input logic we, input logic [AW-1:0] a,
                          input logic [11:0] d);
        int n;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ack && n < 60);
        chk("cpu_ack_wait", cpu_ack === 1'b1, n, 60);
        cpu_req = 1'b0;
        cpu_we = 1'($urandom);
        cpu_addr = AW'($urandom);
        cpu_wdata = 12'($urandom);
    endtask

    task automatic db_op(input logic we, input logic inc,
                         input logic [AW-1:0] a, input logic [11:0] d);
        int n;
        @(negedge clk);
        db_req = 1'b1; db_we = we; db_inc = inc; db_addr = a; db_wdata = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!db_ack && n < 60);
        chk("db_ack_wait", db_ack === 1'b1, n, 60);
        db_req = 1'b0;
        db_we = 1'($urandom);
        db_inc = 1'($urandom);
        db_addr = AW'($urandom);
        db_wdata = 12'($urandom);
    endtask

    task automatic db_stream(input int n, input logic [AW-1:0] a);
        int got, t;
        got = 0;
        t = 0;
        @(negedge clk);
        db_req = 1'b1; db_we = 1'b0; db_inc = 1'b0; db_addr = a;
        while (got < n && t < 300) begin
            @(negedge clk);
            t++;
            if (db_ack) got++;
        end
        db_req = 1'b0;
        chk("db_stream_grants", got == n, got, n);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((cpu_q.size() > 0 || db_q.size() > 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain", cpu_q.size() == 0 && db_q.size() == 0,
            cpu_q.size() + db_q.size(), 0);
    endtask

    function automatic logic [71:0] all_outs();
        return {cpu_ack, cpu_rvalid, cpu_rdata, db_ack, db_rvalid, db_rdata,
                db_ovf, mem_raddr, mem_waddr, mem_wren, mem_wdata};
    endfunction

    logic [AW-1:0] pool [8];

    initial begin
        logic [71:0] outs;
        int          base;
        int          k;
        logic        exp_d;
        pool = '{15'o00200, 15'o10000, 15'o10001, 15'h7fff,
                 15'h0000, 15'o00201, 15'h1234, 15'h4000};

        // reset state
        @(posedge clk);
        @(negedge clk);
        mon_en = 1;
        @(negedge clk);
        outs = all_outs();
        chk("reset_outputs", outs === '0, longint'(outs[63:0]), 0);
        rst_n = 1'b1;

        // write then read back
        cpu_op(1'b1, 15'o00200, 12'o1234);
        cpu_op(1'b0, 15'o00200, 12'o0000);
        drain();
        chk("t1_rdata_hold", cpu_rdata === 12'o1234, cpu_rdata, 12'o1234);
        chk("t1_core", core[15'o00200] === 12'o1234, core[15'o00200], 12'o1234);

        // simultaneous requests: data-break first
        base = glog.size();
        fork
            db_op(1'b0, 1'b0, 15'o00200, 12'o0);
            cpu_op(1'b0, 15'o00201, 12'o0);
        join
        drain();
        chk("t2_len", glog.size() - base == 2, glog.size() - base, 2);
        if (glog.size() - base == 2) begin
            chk("t2_first_db", glog[base] === 1'b1, glog[base], 1);
            chk("t2_then_cpu", glog[base+1] === 1'b0, glog[base+1], 0);
        end

        // starvation limit: DBM db grants, one cpu grant, db resumes
        base = glog.size();
        fork
            db_stream(DBM + 2, 15'h1234);
            cpu_op(1'b0, 15'h4000, 12'o0);
        join
        drain();
        chk("t3_len", glog.size() - base == DBM + 3, glog.size() - base, DBM + 3);
        if (glog.size() - base == DBM + 3) begin
            for (int i = 0; i < DBM + 3; i++) begin
                exp_d = (i != DBM);
                chk("t3_order", glog[base+i] === exp_d, i, exp_d);
            end
        end

        // data-break increment (or plain read when the feature is off)
        cpu_op(1'b1, 15'o10000, 12'o7777);
        db_op(1'b0, 1'b1, 15'o10000, 12'o0);
        drain();
`ifdef DB_INCR_EN
        chk("t4_wrap_rdata", db_rdata === 12'o0000, db_rdata, 0);
        chk("t4_wrap_core", core[15'o10000] === 12'o0000, core[15'o10000], 0);
`else
        chk("t6_wrap_rdata", db_rdata === 12'o7777, db_rdata, 12'o7777);
        chk("t6_wrap_core", core[15'o10000] === 12'o7777, core[15'o10000], 12'o7777);
`endif
        cpu_op(1'b1, 15'o10001, 12'o0005);
        db_op(1'b0, 1'b1, 15'o10001, 12'o0);
        drain();
`ifdef DB_INCR_EN
        chk("t4_inc_rdata", db_rdata === 12'o0006, db_rdata, 12'o0006);
        chk("t4_inc_core", core[15'o10001] === 12'o0006, core[15'o10001], 12'o0006);
`else
        chk("t6_inc_rdata", db_rdata === 12'o0005, db_rdata, 12'o0005);
        chk("t6_inc_core", core[15'o10001] === 12'o0005, core[15'o10001], 12'o0005);
`endif

        // reset during RD2 aborts the read
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'o00201;
        k = 0;
        do begin @(negedge clk); k++; end while (!cpu_ack && k < 60);
        chk("t5_rd_ack", cpu_ack === 1'b1, k, 60);
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        flush_cnt++;
        @(negedge clk);
        outs = all_outs();
        chk("t5_rd_reset_outs", outs === '0, longint'(outs[63:0]), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // reset during the write cycle: memory still takes the data
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h7fff; cpu_wdata = 12'o4321;
        k = 0;
        do begin @(negedge clk); k++; end while (!cpu_ack && k < 60);
        chk("t5_wr_ack", cpu_ack === 1'b1, k, 60);
        cpu_req = 1'b0;
        rst_n = 1'b0;
        flush_cnt++;
        @(negedge clk);
        outs = all_outs();
        chk("t5_wr_reset_outs", outs === '0, longint'(outs[63:0]), 0);
        chk("t5_wr_core", core[15'h7fff] === 12'o4321, core[15'h7fff], 12'o4321);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // random mixed traffic
        for (int it = 0; it < 150; it++) begin
            k = $urandom_range(0, 2);
            if (k == 0) begin
                cpu_op(1'($urandom), pool[$urandom_range(0, 7)], 12'($urandom));
            end else if (k == 1) begin
                db_op(1'($urandom), 1'($urandom), pool[$urandom_range(0, 7)],
                      12'($urandom));
            end else begin
                fork
                    cpu_op(1'($urandom), pool[$urandom_range(0, 7)], 12'($urandom));
                    db_op(1'($urandom), 1'($urandom), pool[$urandom_range(0, 7)],
                          12'($urandom));
                join
            end
        end
        drain();

        for (int i = 0; i < 8; i++)
            chk("mem_final", core[pool[i]] === ref_mem[pool[i]],
                core[pool[i]], ref_mem[pool[i]]);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
